// File: rtl/debounce_timer_arbiter_if.sv
// Pin-side bundle for debounce_timer_arbiter: raw inputs in, debounced levels and edge pulses out.
// Optional abort_count exists only when DEBOUNCE_ABORT_CNT_EN is defined.
interface debounce_timer_arbiter_if #(
  parameter int N = 4
);
  // No valid/ready handshake here: noisy is a free-running level, debounced is a level,
  // rise_tick/fall_tick are single-cycle pulses, and active_idx is meaningful only while busy=1.
  logic [N-1:0] noisy;
  logic [N-1:0] debounced;
  logic [N-1:0] rise_tick;
  logic [N-1:0] fall_tick;
  logic         busy;
  logic [3:0]   active_idx;
  logic [1:0]   fsm_state;
`ifdef DEBOUNCE_ABORT_CNT_EN
  logic [15:0]  abort_count;
`endif

  modport master (
    output noisy,
    input  debounced, rise_tick, fall_tick, busy, active_idx, fsm_state
`ifdef DEBOUNCE_ABORT_CNT_EN
    , input abort_count
`endif
  );

  modport slave (
    input  noisy,
    output debounced, rise_tick, fall_tick, busy, active_idx, fsm_state
`ifdef DEBOUNCE_ABORT_CNT_EN
    , output abort_count
`endif
  );
endinterface

// File: rtl/debounce_timer_arbiter.sv
// N-input debouncer sharing one stability timer through a round-robin grant.
// Define DEBOUNCE_ABORT_CNT_EN to add the saturating abort_count output.
module debounce_timer_arbiter #(
  parameter int N            = 4,
  parameter int DELAY_CYCLES = 5_000_000,
  parameter int CNT_W        = 23
) (
  input logic                    clk,
  input logic                    reset,
  debounce_timer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  logic [N-1:0]     deb;
  logic [N-1:0]     rise_q;
  logic [N-1:0]     fall_q;
  logic [N-1:0]     req;
  logic [N-1:0]     sel_mask;
  logic             req_active;
  logic [3:0]       active_idx;
  logic [3:0]       last_grant;
  logic [3:0]       grant_idx;
  logic             grant_valid;
  logic [15:0]      req_ext;
  logic [4:0]       cand_sum;
  logic [CNT_W-1:0] counter;
  logic             do_grant;
  logic             do_abort;
  logic             do_commit;
  logic             cnt_inc;

  assign req        = s2 ^ deb;
  assign req_ext    = 16'(req);
  assign sel_mask   = N'(1) << active_idx;
  assign req_active = |(req & sel_mask);

  // Scan starts one past the last grant so an aborted index also loses priority.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_sum    = '0;
    for (int k = 1; k <= N; k++) begin
      cand_sum = {1'b0, last_grant} + 5'(k);
      if (cand_sum >= 5'(N)) cand_sum = cand_sum - 5'(N);
      if (!grant_valid && req_ext[cand_sum[3:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_sum[3:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_abort   = 1'b0;
    do_commit  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          do_grant   = 1'b1;
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (!req_active) begin
          do_abort   = 1'b1;
          state_next = IDLE;
        end else if (counter == CNT_W'(DELAY_CYCLES - 1)) begin
          state_next = COMMIT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      COMMIT: begin
        do_commit  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      s1         <= '0;
      s2         <= '0;
      deb        <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      active_idx <= '0;
      last_grant <= 4'(N - 1);
      counter    <= '0;
    end else begin
      state  <= state_next;
      s1     <= bus.noisy;
      s2     <= s1;
      rise_q <= '0;
      fall_q <= '0;
      if (do_grant) begin
        active_idx <= grant_idx;
        last_grant <= grant_idx;
        counter    <= '0;
      end
      if (cnt_inc) counter <= counter + CNT_W'(1);
      if (do_commit) begin
        deb <= deb ^ sel_mask;
        if (|(deb & sel_mask)) fall_q <= sel_mask;
        else                   rise_q <= sel_mask;
      end
    end
  end

`ifdef DEBOUNCE_ABORT_CNT_EN
  logic [15:0] abort_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      abort_cnt <= '0;
    end else if (do_abort && abort_cnt != 16'hFFFF) begin
      abort_cnt <= abort_cnt + 16'd1;
    end
  end

  assign bus.abort_count = abort_cnt;
`else
  logic unused_abort;
  assign unused_abort = do_abort;
`endif

  assign bus.debounced  = deb;
  assign bus.rise_tick  = rise_q;
  assign bus.fall_tick  = fall_q;
  assign bus.busy       = (state == COUNT) || (state == COMMIT);
  assign bus.active_idx = active_idx;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Directed bench for debounce_timer_arbiter with N=4, DELAY_CYCLES=8.
// Edge numbers in comments count from the first clock edge that samples a new noisy value (E0).
module tb_debounce_timer_arbiter;

  localparam int N     = 4;
  localparam int DELAY = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  logic [N-1:0] rise_seen;
  logic [N-1:0] fall_seen;

  debounce_timer_arbiter_if #(.N(N)) bus ();

  debounce_timer_arbiter #(
    .N(N),
    .DELAY_CYCLES(DELAY),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rise_seen = rise_seen | bus.rise_tick;
      fall_seen = fall_seen | bus.fall_tick;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    step(cycles);
    reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rise_seen    = '0;
    fall_seen    = '0;
    reset        = 1'b1;
    bus.noisy    = 4'b1111;

    // Reset with all inputs high
    step(3);
    check("rst_debounced", 32'(bus.debounced), 32'h0);
    check("rst_rise", 32'(bus.rise_tick), 32'h0);
    check("rst_fall", 32'(bus.fall_tick), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_active", 32'(bus.active_idx), 32'h0);
`ifdef DEBOUNCE_ABORT_CNT_EN
    check("rst_abort_cnt", 32'(bus.abort_count), 32'h0);
`endif
    reset = 1'b0;
    step(2);                                   // E1
    check("first_busy_e1", 32'(bus.busy), 32'h0);
    step(1);                                   // E2
    check("first_busy_e2", 32'(bus.busy), 32'h1);
    check("first_grant_idx0", 32'(bus.active_idx), 32'h0);
    step(9);                                   // E11
    check("first_deb", 32'(bus.debounced), 32'h1);
    check("first_rise", 32'(bus.rise_tick), 32'h1);
    step(1);                                   // E12
    check("second_grant_idx1", 32'(bus.active_idx), 32'h1);
    bus.noisy = 4'b0000;
    do_reset(2);

    // Clean press on input 2
    bus.noisy = 4'b0100;
    step(2);                                   // E1
    check("press_busy_e1", 32'(bus.busy), 32'h0);
    step(1);                                   // E2
    check("press_busy_e2", 32'(bus.busy), 32'h1);
    check("press_active", 32'(bus.active_idx), 32'h2);
    step(8);                                   // E10
    check("press_state_commit", 32'(bus.fsm_state), 32'h2);
    check("press_deb_e10", 32'(bus.debounced), 32'h0);
    step(1);                                   // E11
    check("press_deb_e11", 32'(bus.debounced), 32'h4);
    check("press_rise_e11", 32'(bus.rise_tick), 32'h4);
    check("press_busy_e11", 32'(bus.busy), 32'h0);
    step(1);                                   // E12
    check("press_rise_e12", 32'(bus.rise_tick), 32'h0);
    check("press_deb_e12", 32'(bus.debounced), 32'h4);

    // Release input 2
    bus.noisy = 4'b0000;
    step(11);                                  // E10
    check("release_fall_e10", 32'(bus.fall_tick), 32'h0);
    step(1);                                   // E11
    check("release_fall_e11", 32'(bus.fall_tick), 32'h4);
    check("release_deb_e11", 32'(bus.debounced), 32'h0);

    // Bounce on input 1: five cycles high then low again
    step(1);
    rise_seen = '0;
    fall_seen = '0;
    bus.noisy = 4'b0010;
    step(5);                                   // E4
    check("bounce_busy_e4", 32'(bus.busy), 32'h1);
    check("bounce_active", 32'(bus.active_idx), 32'h1);
    bus.noisy = 4'b0000;
    step(2);                                   // E6
    check("bounce_busy_e6", 32'(bus.busy), 32'h1);
    step(1);                                   // E7
    check("bounce_abort_busy", 32'(bus.busy), 32'h0);
`ifdef DEBOUNCE_ABORT_CNT_EN
    check("bounce_abort_cnt", 32'(bus.abort_count), 32'h1);
`endif
    step(13);                                  // E20
    check("bounce_deb", 32'(bus.debounced), 32'h0);
    check("bounce_no_tick", 32'({rise_seen, fall_seen}), 32'h0);

    // Round-robin: last grant was 1, so 2 wins over 0
    bus.noisy = 4'b0101;
    step(3);                                   // E2
    check("rr_first_idx2", 32'(bus.active_idx), 32'h2);
    step(9);                                   // E11
    check("rr_deb_e11", 32'(bus.debounced), 32'h4);
    check("rr_rise_e11", 32'(bus.rise_tick), 32'h4);
    step(1);                                   // E12
    check("rr_second_idx0", 32'(bus.active_idx), 32'h0);
    check("rr_busy_e12", 32'(bus.busy), 32'h1);
    check("rr_rise_e12", 32'(bus.rise_tick), 32'h0);
    step(9);                                   // E21
    check("rr_deb_e21", 32'(bus.debounced), 32'h5);
    check("rr_rise_e21", 32'(bus.rise_tick), 32'h1);

    // Release both: pointer at 0, so 2 falls first
    bus.noisy = 4'b0000;
    step(12);                                  // E11
    check("rr_rel_deb_e11", 32'(bus.debounced), 32'h1);
    check("rr_rel_fall_e11", 32'(bus.fall_tick), 32'h4);
    step(10);                                  // E21
    check("rr_rel_deb_e21", 32'(bus.debounced), 32'h0);
    check("rr_rel_fall_e21", 32'(bus.fall_tick), 32'h1);

    // Contention after reset: 0 before 3
    do_reset(2);
`ifdef DEBOUNCE_ABORT_CNT_EN
    check("reset_clears_abort_cnt", 32'(bus.abort_count), 32'h0);
`endif
    bus.noisy = 4'b1001;
    step(12);                                  // E11
    check("cont_deb_e11", 32'(bus.debounced), 32'h1);
    check("cont_rise_e11", 32'(bus.rise_tick), 32'h1);
    step(1);                                   // E12
    check("cont_rise_e12", 32'(bus.rise_tick), 32'h0);
    check("cont_active_e12", 32'(bus.active_idx), 32'h3);
    step(9);                                   // E21
    check("cont_deb_e21", 32'(bus.debounced), 32'h9);
    check("cont_rise_e21", 32'(bus.rise_tick), 32'h8);

    // Reset in the middle of COUNT for input 3
    bus.noisy = 4'b0000;
    do_reset(2);
    bus.noisy = 4'b1000;
    step(7);                                   // E6, counter=4
    check("midrst_busy", 32'(bus.busy), 32'h1);
    check("midrst_active", 32'(bus.active_idx), 32'h3);
    rise_seen = '0;
    fall_seen = '0;
    do_reset(2);
    check("midrst_deb", 32'(bus.debounced), 32'h0);
    check("midrst_busy_after", 32'(bus.busy), 32'h0);
    check("midrst_no_tick", 32'({rise_seen, fall_seen}), 32'h0);
    step(11);                                  // E10 after release
    check("midrst_deb_e10", 32'(bus.debounced), 32'h0);
    step(1);                                   // E11
    check("midrst_deb_e11", 32'(bus.debounced), 32'h8);
    check("midrst_rise_e11", 32'(bus.rise_tick), 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/debounce_timer_arbiter.md
Name: debounce_timer_arbiter

Overview:
- Debounces N independent push-button/switch inputs using one shared stability timer, replacing N per-input debouncers and their N wide counters.
- Each input gets a 2-flop synchronizer and a debounced state bit. Any input whose synchronized level differs from its debounced state requests the timer.
- A round-robin scheduler grants the timer to one requester at a time. The block sits between the board pins and the user-logic edge detectors.

Parameters:
- N, 4, number of noisy inputs (2..16).
- DELAY_CYCLES, 5_000_000, stability window in clk cycles (50 ms at 100 MHz); must be >= 2.
- CNT_W, 23, timer width; must satisfy 2**CNT_W > DELAY_CYCLES.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, synchronous active-high reset.
- noisy, input, N, raw asynchronous inputs.
- debounced, output, N, registered debounced levels.
- rise_tick, output, N, one-cycle pulse when debounced[i] goes 0->1.
- fall_tick, output, N, one-cycle pulse when debounced[i] goes 1->0.
- busy, output, 1, high while state is COUNT or COMMIT.
- active_idx, output, 4, index currently holding the timer; valid when busy=1.

Behaviour:
- Reset (sampled on a rising edge while reset=1):
  - sync flops, debounced, rise_tick, fall_tick, busy, active_idx, counter all 0.
  - state=IDLE; last_grant=N-1, so index 0 has first priority.
  - Reset overrides all other activity. Reset during COUNT aborts with no tick and no debounced change.
- Synchronizer: s1<=noisy, s2<=s1 for every input. req[i] = s2[i] XOR debounced[i].
- FSM IDLE:
  - If any req is set, grant the first set index scanning from last_grant+1 modulo N.
  - On grant: active_idx<=grant, last_grant<=grant, counter<=0, state->COUNT. Otherwise stay in IDLE.
- FSM COUNT:
  - If req[active_idx]=0 (input returned to its debounced level): abort, state->IDLE.
  - Else if counter==DELAY_CYCLES-1: state->COMMIT.
  - Else counter++.
  - Requests on other indices are ignored until the next IDLE.
- FSM COMMIT:
  - debounced[active_idx] toggles.
  - The matching rise_tick or fall_tick is high for exactly the next cycle.
  - state->IDLE unconditionally. Input activity during COMMIT does not cancel the commit; a new mismatch simply re-requests.
- Latency, timer free:
  - noisy sampled on edge E0 -> req visible after E1 -> grant at E2 -> COMMIT entered at E2+DELAY_CYCLES -> debounced toggles at E0+DELAY_CYCLES+3.
  - Tick is high for the single cycle after that edge.
- Service cost: DELAY_CYCLES+2 cycles per granted index (COUNT + COMMIT + IDLE).
  - Worst-case wait before a grant is (N-1)*(DELAY_CYCLES+2) cycles.
  - Round-robin guarantees no starvation.
- Ticks: at most one tick bit is set in any cycle. rise_tick and fall_tick are never set together.
- Abort: the pointer still advances past the aborted index, so a chattering input cannot monopolise the timer.
- Counter never wraps: it is compared and cleared before reaching 2**CNT_W-1.

Optional Feature:
- Macro: DEBOUNCE_ABORT_CNT_EN.
- Defined:
  - Adds output abort_count[15:0], reset to 0.
  - Increments by 1 on each COUNT abort and saturates at 16'hFFFF.
  - Reset clears it.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan (N=4, DELAY_CYCLES=8):
- Reset: hold reset 3 cycles with noisy=4'b1111 -> debounced=0, ticks=0, busy=0. After release, index 0 is granted first.
- Clean press: noisy[2] 0->1, held, first sampled at edge E0 -> busy=1 and active_idx=2 from E2; debounced[2]=1 at E0+11; rise_tick=4'b0100 for exactly one cycle. Release noisy[2] -> fall_tick[2] pulses 11 edges later.
- Bounce: noisy[1] high for 5 cycles then low -> abort in COUNT; debounced[1] stays 0; no tick; abort_count=1 when enabled.
- Contention: noisy[0] and noisy[3] rise in the same cycle (E0) -> debounced[0] at E0+11, debounced[3] at E0+21; ticks in different cycles.
- Round-robin: after index 1 is serviced, raise noisy[0] and noisy[2] together -> 2 is granted before 0.
- Reset mid-COUNT: assert reset at counter=4 for noisy[3] -> no tick and debounced=0. After release with noisy[3] still high, full debounce restarts and completes 11 edges after the first post-reset sample.
